// File: rtl/blk_cf0525.sv
// Instruction-fetch stage: owns the PC, issues one imem word fetch at a time and
// presents the fetched slot's PC/order to ID, with stall hold and redirect squash.
package blk_cf0525_pkg;
  typedef struct packed {
    logic        valid_s;
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [63:0] order_s;
  } if_id_stage_reg_t;
endpackage

module blk_cf0525
  import blk_cf0525_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1ECEB000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             move,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  output logic [3:0]       imem_rmask,
  input  logic             imem_resp,
  output if_id_stage_reg_t if_id_reg
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [63:0] order;
  logic [3:0]  rmask_q;
  logic        valid_s;
  logic        consume;
  logic [31:0] pc_inc;
  logic [31:0] redirect_tgt;

  assign pc_inc       = pc + 32'd4;
  assign redirect_tgt = redirect_pc & ~32'h3;

  always_comb begin
    valid_s = 1'b0;
    unique case (state)
      WAIT:    valid_s = imem_resp & ~redirect_valid;
      HOLD:    valid_s = ~redirect_valid;
      default: valid_s = 1'b0;
    endcase
  end

  assign consume = valid_s & move;

  // In FETCH, rmask_q==0 marks the idle cycle right after reset release:
  // the request goes out on the following cycle instead of during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      order   <= 64'd0;
      rmask_q <= 4'h0;
    end else begin
      rmask_q <= 4'h0;
      if (consume)
        order <= order + 64'd1;
      if (redirect_valid) begin
        pc <= redirect_tgt;
        unique case (state)
          FETCH: begin
            if (rmask_q == 4'hF) state <= DROP;
            else                 rmask_q <= 4'hF;
          end
          WAIT: begin
            if (imem_resp) begin
              state   <= FETCH;
              rmask_q <= 4'hF;
            end else begin
              state   <= DROP;
            end
          end
          HOLD: begin
            state   <= FETCH;
            rmask_q <= 4'hF;
          end
          DROP: begin
            if (imem_resp) begin
              state   <= FETCH;
              rmask_q <= 4'hF;
            end
          end
        endcase
      end else begin
        unique case (state)
          FETCH: begin
            if (rmask_q == 4'hF) state <= WAIT;
            else                 rmask_q <= 4'hF;
          end
          WAIT: begin
            if (imem_resp && move) begin
              pc      <= pc_inc;
              state   <= FETCH;
              rmask_q <= 4'hF;
            end else if (imem_resp) begin
              state   <= HOLD;
            end
          end
          HOLD: begin
            if (move) begin
              pc      <= pc_inc;
              state   <= FETCH;
              rmask_q <= 4'hF;
            end
          end
          DROP: begin
            if (imem_resp) begin
              state   <= FETCH;
              rmask_q <= 4'hF;
            end
          end
        endcase
      end
    end
  end

  assign imem_addr           = pc;
  assign imem_rmask          = rmask_q;
  assign if_id_reg.valid_s   = valid_s;
  assign if_id_reg.pc_s      = pc;
  assign if_id_reg.pc_next_s = pc_inc;
  assign if_id_reg.order_s   = order;

endmodule

// File: tb/tb_blk_cf0525.sv
// Scenario bench for the IF stage: requests push expected {pc, order} entries,
// ID-visible valid slots are compared against the head of that queue.
`timescale 1ns/1ps
module tb_blk_cf0525;
  import blk_cf0525_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1ECEB000;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] ord;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             move = 1'b1;
  logic             redirect_valid = 1'b0;
  logic [31:0]      redirect_pc = 32'h0;
  logic [31:0]      imem_addr;
  logic [3:0]       imem_rmask;
  logic             imem_resp = 1'b0;
  if_id_stage_reg_t if_id_reg;

  exp_t        sb[$];
  logic [63:0] model_order = 64'd0;
  int          errors = 0;
  int          checks = 0;

  blk_cf0525 #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .move(move), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_resp(imem_resp), .if_id_reg(if_id_reg)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a request; returns with time at that cycle's negedge.
  task automatic wait_req(input logic [31:0] exp_addr, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (imem_rmask !== 4'hF && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (imem_rmask !== 4'hF) begin
      errors++;
      $display("FAIL req_timeout addr_exp=%h rmask=%h", exp_addr, imem_rmask);
    end else begin
      checks++;
      if (imem_addr !== exp_addr) begin
        errors++;
        $display("FAIL req_addr got=%h exp=%h", imem_addr, exp_addr);
      end
      checks++;
      if (if_id_reg.valid_s !== 1'b0) begin
        errors++;
        $display("FAIL valid_in_fetch got=%b exp=0", if_id_reg.valid_s);
      end
    end
    e.pc  = exp_addr;
    e.ord = model_order;
    sb.push_back(e);
  endtask

  // Called just after a posedge while in WAIT: drives the response cycle.
  task automatic resp_cycle(input logic mv);
    exp_t e;
    imem_resp = 1'b1;
    move      = mv;
    @(negedge clk);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty valid=%b", if_id_reg.valid_s);
    end else begin
      e = sb[0];
      if (if_id_reg.valid_s !== 1'b1 || if_id_reg.pc_s !== e.pc ||
          if_id_reg.pc_next_s !== e.pc + 32'd4 || if_id_reg.order_s !== e.ord) begin
        errors++;
        $display("FAIL resp_slot got v=%b pc=%h nx=%h ord=%0d exp v=1 pc=%h nx=%h ord=%0d",
                 if_id_reg.valid_s, if_id_reg.pc_s, if_id_reg.pc_next_s, if_id_reg.order_s,
                 e.pc, e.pc + 32'd4, e.ord);
      end
      if (mv) begin
        void'(sb.pop_front());
        model_order++;
      end
    end
    next_cycle();
    imem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_rmask !== 4'h0 || imem_addr !== RST_PC || if_id_reg.valid_s !== 1'b0 ||
        if_id_reg.pc_s !== RST_PC || if_id_reg.pc_next_s !== RST_PC + 32'd4 ||
        if_id_reg.order_s !== 64'd0) begin
      errors++;
      $display("FAIL reset_state got rmask=%h addr=%h v=%b pc=%h nx=%h ord=%0d",
               imem_rmask, imem_addr, if_id_reg.valid_s, if_id_reg.pc_s,
               if_id_reg.pc_next_s, if_id_reg.order_s);
    end
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    int w;
    for (int k = 0; k < 3; k++) begin
      wait_req(RST_PC + 32'(4 * k), w);
      if (k > 0) begin
        checks++;
        if (w !== 0) begin
          errors++;
          $display("FAIL b2b_gap got=%0d exp=0", w);
        end
      end
      next_cycle();
      resp_cycle(1'b1);
    end
  endtask

  task automatic test_hold();
    int w;
    wait_req(RST_PC + 32'hC, w);
    next_cycle();
    resp_cycle(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (if_id_reg.valid_s !== 1'b1 || if_id_reg.pc_s !== RST_PC + 32'hC ||
          imem_rmask !== 4'h0 || if_id_reg.order_s !== model_order) begin
        errors++;
        $display("FAIL hold got v=%b pc=%h rmask=%h ord=%0d exp v=1 pc=%h rmask=0 ord=%0d",
                 if_id_reg.valid_s, if_id_reg.pc_s, imem_rmask, if_id_reg.order_s,
                 RST_PC + 32'hC, model_order);
      end
      next_cycle();
    end
    move = 1'b1;
    @(negedge clk);
    checks++;
    if (if_id_reg.valid_s !== 1'b1 || if_id_reg.order_s !== sb[0].ord) begin
      errors++;
      $display("FAIL hold_release got v=%b ord=%0d exp v=1 ord=%0d",
               if_id_reg.valid_s, if_id_reg.order_s, sb[0].ord);
    end
    void'(sb.pop_front());
    model_order++;
    wait_req(RST_PC + 32'h10, w);
    next_cycle();
    resp_cycle(1'b1);
  endtask

  task automatic test_redirect_wait();
    int w;
    wait_req(RST_PC + 32'h14, w);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1ECEB103;
    @(negedge clk);
    checks++;
    if (if_id_reg.valid_s !== 1'b0) begin
      errors++;
      $display("FAIL redir_wait_valid got=%b exp=0", if_id_reg.valid_s);
    end
    void'(sb.pop_front());
    next_cycle();
    redirect_valid = 1'b0;
    imem_resp      = 1'b1;
    @(negedge clk);
    checks++;
    if (if_id_reg.valid_s !== 1'b0 || imem_rmask !== 4'h0) begin
      errors++;
      $display("FAIL dropped_resp got v=%b rmask=%h exp v=0 rmask=0",
               if_id_reg.valid_s, imem_rmask);
    end
    next_cycle();
    imem_resp = 1'b0;
    wait_req(32'h1ECEB100, w);
    next_cycle();
    resp_cycle(1'b1);
  endtask

  task automatic test_redirect_resp();
    int w;
    wait_req(32'h1ECEB104, w);
    next_cycle();
    imem_resp      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    @(negedge clk);
    checks++;
    if (if_id_reg.valid_s !== 1'b0) begin
      errors++;
      $display("FAIL redir_resp_valid got=%b exp=0", if_id_reg.valid_s);
    end
    void'(sb.pop_front());
    next_cycle();
    imem_resp      = 1'b0;
    redirect_valid = 1'b0;
    wait_req(32'h0000_2000, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL redir_resp_gap got=%0d exp=0", w);
    end
    next_cycle();
    resp_cycle(1'b1);
  endtask

  task automatic test_wrap();
    int w;
    wait_req(32'h0000_2004, w);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    @(negedge clk);
    void'(sb.pop_front());
    next_cycle();
    redirect_valid = 1'b0;
    imem_resp      = 1'b1;
    next_cycle();
    imem_resp = 1'b0;
    wait_req(32'hFFFF_FFFC, w);
    next_cycle();
    imem_resp = 1'b1;
    @(negedge clk);
    checks++;
    if (if_id_reg.pc_next_s !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc_next got=%h exp=00000000", if_id_reg.pc_next_s);
    end
    next_cycle();
    imem_resp = 1'b0;
    void'(sb.pop_front());
    model_order++;
    wait_req(32'h0000_0000, w);
  endtask

  task automatic test_async_reset();
    int w;
    next_cycle();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (imem_rmask !== 4'h0 || imem_addr !== RST_PC || if_id_reg.valid_s !== 1'b0 ||
        if_id_reg.order_s !== 64'd0) begin
      errors++;
      $display("FAIL async_reset got rmask=%h addr=%h v=%b ord=%0d",
               imem_rmask, imem_addr, if_id_reg.valid_s, if_id_reg.order_s);
    end
    next_cycle();
    next_cycle();
    rst = 1'b1;
    sb.delete();
    model_order = 64'd0;
    wait_req(RST_PC, w);
    checks++;
    if (w !== 1) begin
      errors++;
      $display("FAIL restart_latency got=%0d exp=1", w);
    end
    next_cycle();
    resp_cycle(1'b1);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold();
    test_redirect_wait();
    test_redirect_resp();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
